// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory Wishbone loader.
//   - register offsets within the 4 KiB window and CTRL/STATUS bit indices
//   - loader FSM state encoding and address-region encoding
//   - decode(): maps a Wishbone byte address to the region it selects
package imem_loader_pkg;

  localparam int CNT_W = 10;

  localparam logic [11:0] CTRL_OFF = 12'h800;
  localparam logic [11:0] STAT_OFF = 12'h804;

  localparam int CTRL_HOLD_BIT = 0;
  localparam int CTRL_CLR_BIT  = 1;
  localparam int STAT_HOLD_BIT = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    ACK  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    RGN_NONE  = 3'd0,  // outside the window: never acked
    RGN_IMEM  = 3'd1,
    RGN_CTRL  = 3'd2,
    RGN_STAT  = 3'd3,
    RGN_OTHER = 3'd4   // unmapped offset inside the window: acked, reads 0
  } region_t;

  function automatic region_t decode(input logic [31:0] adr, input logic [31:0] base);
    region_t r;
    if (adr[31:12] != base[31:12]) begin
      r = RGN_NONE;
    end else if (!adr[11]) begin
      r = RGN_IMEM;
    end else if (adr[11:0] == CTRL_OFF) begin
      r = RGN_CTRL;
    end else if (adr[11:0] == STAT_OFF) begin
      r = RGN_STAT;
    end else begin
      r = RGN_OTHER;
    end
    return r;
  endfunction

endpackage

// File: rtl/imem_wb_loader.sv
// Wishbone slave giving the management SoC access to port 0 of the 32x512
// instruction SRAM, plus a CTRL register (core_hold, clr_cnt) and a STATUS
// register (wr_cnt, core_hold).
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i      Wishbone classic cycle, strobe, write enable
//   wbs_sel_i, wbs_adr_i      byte selects, byte address
//   wbs_dat_i                 write data
//   wbs_ack_o, wbs_dat_o      registered acknowledge and read data
//   csb0, web0, wmask0        SRAM port-0 chip select / write enable (low), byte mask
//   addr0, din0, dout0        SRAM port-0 word address, write data, read data
//   core_hold                 keeps the core in reset while a program is loaded
//   dbg_state                 current FSM state, for observation only
//
// Handshake: a request is accepted when cyc & stb are high in IDLE and the
// previous ack has already dropped; ack is then high for exactly one cycle.
// Once accepted, the sequence always runs to completion even if the master
// drops cyc/stb early; only reset abandons it.
module imem_wb_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          AW        = 9
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic          csb0,
  output logic          web0,
  output logic [3:0]    wmask0,
  output logic [AW-1:0] addr0,
  output logic [31:0]   din0,
  input  logic [31:0]   dout0,
  output logic          core_hold,
  output logic [2:0]    dbg_state
);

  state_t             state, state_n;
  logic               ack_n;
  logic [31:0]        dat_n;
  logic               csb_n, web_n;
  logic [3:0]         wmask_n;
  logic [AW-1:0]      addr_n;
  logic [31:0]        din_n;
  logic               hold_n;
  logic [CNT_W-1:0]   wr_cnt, cnt_n;
  region_t            rgn;
  logic [31:0]        stat_word;
  logic [31:0]        ctrl_word;

  assign dbg_state = state;
  assign rgn       = decode(wbs_adr_i, BASE_ADDR);

  always_comb begin
    stat_word                = '0;
    stat_word[CNT_W-1:0]     = wr_cnt;
    stat_word[STAT_HOLD_BIT] = core_hold;
    ctrl_word                = '0;
    ctrl_word[CTRL_HOLD_BIT] = core_hold;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      csb0      <= 1'b1;
      web0      <= 1'b1;
      wmask0    <= '0;
      addr0     <= '0;
      din0      <= '0;
      core_hold <= 1'b1;
      wr_cnt    <= '0;
    end else begin
      state     <= state_n;
      wbs_ack_o <= ack_n;
      wbs_dat_o <= dat_n;
      csb0      <= csb_n;
      web0      <= web_n;
      wmask0    <= wmask_n;
      addr0     <= addr_n;
      din0      <= din_n;
      core_hold <= hold_n;
      wr_cnt    <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    ack_n   = 1'b0;
    dat_n   = wbs_dat_o;
    csb_n   = 1'b1;
    web_n   = 1'b1;
    wmask_n = wmask0;
    addr_n  = addr0;
    din_n   = din0;
    hold_n  = core_hold;
    cnt_n   = wr_cnt;

    unique case (state)
      IDLE: begin
        // Gating on !wbs_ack_o keeps a strobe that is still high in the
        // cycle the master sees ack from being taken as a second request.
        if (wbs_cyc_i && wbs_stb_i && !wbs_ack_o && rgn != RGN_NONE) begin
          unique case (rgn)
            RGN_IMEM: begin
              addr_n = wbs_adr_i[AW+1:2];
              if (wbs_we_i) begin
                if (wbs_sel_i != 4'b0000) begin
                  csb_n   = 1'b0;
                  web_n   = 1'b0;
                  wmask_n = wbs_sel_i;
                  din_n   = wbs_dat_i;
                  state_n = WR;
                end else begin
                  ack_n   = 1'b1;
                  state_n = ACK;
                end
              end else begin
                csb_n   = 1'b0;
                state_n = RD1;
              end
            end
            RGN_CTRL: begin
              if (wbs_we_i) begin
                // A write carrying clr_cnt is a pure counter-clear command
                // and leaves core_hold alone, so a loader can reset the
                // count without releasing the core.
                if (wbs_sel_i[0]) begin
                  if (wbs_dat_i[CTRL_CLR_BIT]) begin
                    cnt_n = '0;
                  end else begin
                    hold_n = wbs_dat_i[CTRL_HOLD_BIT];
                  end
                end
              end else begin
                dat_n = ctrl_word;
              end
              ack_n   = 1'b1;
              state_n = ACK;
            end
            RGN_STAT: begin
              if (!wbs_we_i) dat_n = stat_word;
              ack_n   = 1'b1;
              state_n = ACK;
            end
            default: begin
              if (!wbs_we_i) dat_n = '0;
              ack_n   = 1'b1;
              state_n = ACK;
            end
          endcase
        end
      end
      WR: begin
        ack_n = 1'b1;
        if (wr_cnt != {CNT_W{1'b1}}) cnt_n = wr_cnt + CNT_W'(1);
        state_n = IDLE;
      end
      RD1: begin
        state_n = RD2;
      end
      RD2: begin
        dat_n   = dout0;
        ack_n   = 1'b1;
        state_n = IDLE;
      end
      ACK: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: doc/imem_wb_loader.md
Name: imem_wb_loader

Overview:
- Wishbone slave that gives the management SoC read/write access to port 0 (1RW) of the 32x512 instruction SRAM.
- Sits directly upstream of the instruction memory: it programs the SRAM before the SLRV core fetches from port 1.
- Provides a control register whose core_hold bit keeps the core in reset while a program is loaded, plus a status register counting words written.

Parameters:
- BASE_ADDR, 32'h3000_0000, base of the 4 KiB decoded window; the window is selected by wbs_adr_i[31:12] == BASE_ADDR[31:12].
- AW, 9, SRAM word-address width (512 words).

Ports:
- wb_clk_i  in  1  single clock for all logic and the SRAM.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic cycle, strobe and write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  32  registered read data.
- csb0  out  1  SRAM port-0 chip select, active low.
- web0  out  1  SRAM port-0 write enable, active low.
- wmask0  out  4  SRAM byte write mask.
- addr0  out  AW  SRAM word address.
- din0  out  32  SRAM write data.
- dout0  in  32  SRAM read data.
- core_hold  out  1  holds the core in reset; the core reset is the OR of wb_rst_i and core_hold.

Behaviour:
- Address map, as offsets within the window:
  - 0x000-0x7FC: IMEM; word address = wbs_adr_i[10:2].
  - 0x800: CTRL. Bit0 is core_hold (R/W). Bit1 is clr_cnt (write-1 pulse, reads 0).
  - 0x804: STATUS (RO). Bits[9:0] = wr_cnt. Bit16 = core_hold.
  - Any other offset in the window: writes are ignored, reads return 0; the access is still acked.
  - Addresses outside the window are never acked.
- Reset: state=IDLE, wbs_ack_o=0, wbs_dat_o=0, csb0=1, web0=1, wmask0=0, addr0=0, din0=0, core_hold=1, wr_cnt=0.
- Reset mid-operation: any in-flight access is abandoned with no ack, and the SRAM strobe drops in the cycle after reset is sampled.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: on cyc&stb&decode, capture the address and data.
    - IMEM write with sel!=0: drive csb0=0, web0=0, wmask0=sel, addr0, din0; go to WR.
    - IMEM write with sel==0: go to ACK with no SRAM access.
    - IMEM read: drive csb0=0, web0=1; go to RD1.
    - Register access: perform it; go to ACK.
  - WR: the SRAM captures on this edge. Deassert csb0/web0, raise ack, increment wr_cnt; go to IDLE.
  - RD1: the SRAM captures. Deassert csb0; go to RD2.
  - RD2: wbs_dat_o <= dout0, raise ack; go to IDLE.
  - ACK: raise ack (register read data loaded into wbs_dat_o); go to IDLE.
- ack is high for exactly one cycle, then forced low.
- A new request may be accepted in the cycle after ack.
- Latency, counting edges from the first edge at which stb is sampled high:
  - Register access: ack high after edge 1.
  - IMEM write: ack high after edge 2.
  - IMEM read: ack high after edge 3.
- If cyc or stb drops before ack, the FSM completes its sequence anyway. The SRAM access still happens and ack still pulses; the master ignores it.
- wr_cnt: 10 bits; saturates at 1023.
  - clr_cnt has priority over a same-cycle increment. This cannot occur structurally but is stated for completeness.
- Writing CTRL bit0=1 while the core runs asserts core_hold on the next edge. Port 0 accesses are permitted regardless of core_hold.
- wbs_dat_o holds its last value between accesses.

Decomposition:
- Shared package imem_loader_pkg holds:
  - offsets CTRL_OFF=12'h800 and STAT_OFF=12'h804;
  - CTRL bit indices;
  - the state enum {IDLE, WR, RD1, RD2, ACK};
  - the word count width.
- No sub-module: the FSM and registers live in one module. The address decode is a single combinational function in the package.

Test Plan:
- After reset → core_hold=1, csb0=1, ack=0; a read of 0x3000_0804 returns 32'h0001_0000 with ack 1 cycle after stb.
- Write 32'hDEAD_BEEF, sel=4'hF to 0x3000_0010 → csb0=0, web0=0, addr0=4, wmask0=F for one cycle; ack on the 2nd edge; STATUS reads 32'h0001_0001.
- Read back 0x3000_0010 → csb0=0, web0=1 for one cycle; wbs_dat_o=DEAD_BEEF with ack on the 3rd edge.
- Partial write: sel=4'b0010, data 32'h0000_AA00, to word 4 → SRAM word reads DEAD_AABEF-merge 32'hDEAD_AAEF. A write with sel=0 → ack with csb0 held high and wr_cnt unchanged.
- Write 1024+5 words, then write CTRL=32'h2 → STATUS count reads 1023 before the CTRL write and 0 after it, with core_hold still 1. Then write CTRL=0 → core_hold=0.
- Pulse wb_rst_i during RD1 → no ack, csb0=1, core_hold=1. An access to 0x3000_1000 (outside the window) → no ack within 10 cycles.
